// File: rtl/spi_peripheral_iomem_if.sv
// iomem register bus between the soft RISC-V core and the SPI peripheral.
// sel is a one-cycle request strobe. ready is tied high, so every sel completes in the cycle
// it is seen: a write lands on the next clk edge, and rdata is combinational from addr.
interface spi_peripheral_iomem_if;
  logic        sel;
  logic [3:0]  wstrb;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (output sel, wstrb, addr, wdata, input ready, rdata);
  modport slave  (input sel, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/spi_peripheral_iomem.sv
// SPI mode-0 responder: host-driven pins are resynchronised into clk, received bytes go to an
// RX FIFO, and MISO shifts out a firmware-loaded holding byte (FILL when none is pending).
module spi_peripheral_iomem #(
  parameter int         RX_DEPTH = 8,
  parameter logic [7:0] FILL     = 8'hFF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         spi_cs_in,
  input  logic                         spi_clk_in,
  input  logic                         spi_mosi_in,
  output logic                         spi_miso_out,
  output logic                         spi_miso_enable,
  spi_peripheral_iomem_if.slave        bus
);
  localparam int            AW    = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam logic [AW:0]   DEPTH = (AW + 1)'(RX_DEPTH);

  logic cs_s1, cs_s2, cs_d;
  logic sck_s1, sck_s2, sck_d;
  logic mosi_s1, mosi_s2;

  logic [2:0] bit_cnt;
  logic       sof;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] tx_hold;
  logic       tx_full;
  logic       overflow;
  logic       underrun;

  logic [8:0]    mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  // Two flops resynchronise the host pins; the third stage on cs/sck gives edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_d    <= 1'b1;
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_d   <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      cs_s1   <= spi_cs_in;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      sck_s1  <= spi_clk_in;
      sck_s2  <= sck_s1;
      sck_d   <= sck_s2;
      mosi_s1 <= spi_mosi_in;
      mosi_s2 <= mosi_s1;
    end
  end

  logic cs_active, cs_fall, cs_rise, sck_rise, sck_fall;
  logic tx_load, push_req, push_ok, pop, full, empty;
  logic rd_stat, wr_ctrl;
  logic [8:0] push_data, head;

  assign cs_active = ~cs_s2;
  assign cs_fall   = cs_d & ~cs_s2;
  assign cs_rise   = ~cs_d & cs_s2;
  assign sck_rise  = sck_s2 & ~sck_d & cs_active;
  assign sck_fall  = ~sck_s2 & sck_d & cs_active;

  assign full      = (count == DEPTH);
  assign empty     = (count == '0);
  assign rd_stat   = bus.sel && (bus.wstrb == 4'b0000) && (bus.addr == 8'h00);
  assign wr_ctrl   = bus.sel && (bus.wstrb != 4'b0000) && (bus.addr == 8'h04);
  assign pop       = rd_stat && !empty;

  // A new TX byte is needed at frame start and on the falling edge that ends each byte.
  assign tx_load   = cs_fall || (sck_fall && (bit_cnt == 3'd0));
  assign push_req  = sck_rise && (bit_cnt == 3'd7);
  assign push_data = {sof, rx_shift, mosi_s2};
  assign push_ok   = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= 3'd0;
      sof      <= 1'b0;
      rx_shift <= 7'd0;
      tx_shift <= FILL;
      tx_hold  <= 8'd0;
      tx_full  <= 1'b0;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (cs_fall) begin
        bit_cnt <= 3'd0;
        sof     <= 1'b1;
      end else if (cs_rise) begin
        bit_cnt <= 3'd0;
      end else if (sck_rise) begin
        rx_shift <= {rx_shift[5:0], mosi_s2};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) sof <= 1'b0;
      end

      if (tx_load)       tx_shift <= tx_full ? tx_hold : FILL;
      else if (sck_fall) tx_shift <= {tx_shift[6:0], 1'b0};

      // A write coinciding with a load keeps tx_full set: the load took the old byte.
      if (wr_ctrl && bus.wstrb[0]) begin
        tx_hold <= bus.wdata[7:0];
        tx_full <= 1'b1;
      end else if (tx_load) begin
        tx_full <= 1'b0;
      end

      if (tx_load && !tx_full)                            underrun <= 1'b1;
      else if (wr_ctrl && bus.wstrb[1] && bus.wdata[9])   underrun <= 1'b0;

      if (push_req && full && !pop)                       overflow <= 1'b1;
      else if (wr_ctrl && bus.wstrb[1] && bus.wdata[8])   overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  assign head            = empty ? 9'd0 : mem[rd_ptr];
  assign spi_miso_out    = tx_shift[7];
  assign spi_miso_enable = cs_active;
  assign bus.ready       = 1'b1;

  always_comb begin
    bus.rdata = 32'd0;
    case (bus.addr)
      8'h00: bus.rdata = {cs_active, overflow, underrun, tx_full, 4'd0,
                          8'(count), 6'd0, head[8], !empty, head[7:0]};
      8'h04: bus.rdata = {28'd0, tx_full, 3'd0};
      default: bus.rdata = 32'd0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{bus.wdata[31:10], bus.wstrb[3:2]};
endmodule

// File: tb/tb_spi_peripheral_iomem.sv
// Directed bench for spi_peripheral_iomem: a host-side SPI driver, iomem register tasks and a
// queue of expected RX FIFO entries {sof, byte} compared as firmware pops them.
module tb_spi_peripheral_iomem;
  localparam int W    = 9;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic reset;
  logic spi_cs, spi_sck, spi_mosi;
  logic spi_miso_out, spi_miso_enable;

  spi_peripheral_iomem_if bus_if ();

  spi_peripheral_iomem #(.RX_DEPTH(8), .FILL(8'hFF)) dut (
    .clk             (clk),
    .reset           (reset),
    .spi_cs_in       (spi_cs),
    .spi_clk_in      (spi_sck),
    .spi_mosi_in     (spi_mosi),
    .spi_miso_out    (spi_miso_out),
    .spi_miso_enable (spi_miso_enable),
    .bus             (bus_if)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare a status word's head fields against the model queue, popping it as the DUT does.
  task automatic cmp_head(input string tag, input logic [31:0] st);
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_head"}, {22'd0, st[9:0]}, {22'd0, e[8], 1'b1, e[7:0]});
    end else begin
      check({tag, "_empty"}, {22'd0, st[9:0]}, 32'd0);
    end
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [3:0] strb, input logic [31:0] d);
    @(negedge clk);
    bus_if.sel = 1'b1; bus_if.addr = a; bus_if.wstrb = strb; bus_if.wdata = d;
    @(negedge clk);
    bus_if.sel = 1'b0; bus_if.wstrb = 4'd0;
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_if.sel = 1'b1; bus_if.addr = a; bus_if.wstrb = 4'd0;
    #1 d = bus_if.rdata;
    @(negedge clk);
    bus_if.sel = 1'b0;
  endtask

  task automatic rd_status(input string tag, output logic [31:0] st);
    read_reg(8'h00, st);
    check({tag, "_count"}, {24'd0, st[23:16]}, exp_q.size());
    cmp_head(tag, st);
  endtask

  task automatic cs_low();
    @(negedge clk) spi_cs = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    spi_cs = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // Shifts d[7], d[6], ... for nbits; returns MISO as sampled at each SCK rise.
  // pop_mid pops the FIFO so the pop lands on the same clk edge as the final bit's push.
  task automatic xfer(input logic [7:0] d, input int nbits, input bit pop_mid,
                      output logic [7:0] miso);
    logic [31:0] st;
    miso = 8'd0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = d[7-i];
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b1;
      miso = {miso[6:0], spi_miso_out};
      if (pop_mid && i == nbits - 1) begin
        repeat (2) @(negedge clk);
        bus_if.sel = 1'b1; bus_if.addr = 8'h00; bus_if.wstrb = 4'd0;
        #1 st = bus_if.rdata;
        check("t5_count_at_pop", {24'd0, st[23:16]}, 32'd8);
        cmp_head("t5_pop", st);
        @(negedge clk);
        bus_if.sel = 1'b0;
        repeat (HALF - 3) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      spi_sck = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] st;
    logic [7:0]  m1, m2, b;

    spi_cs = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    bus_if.sel = 1'b0; bus_if.wstrb = 4'd0; bus_if.addr = 8'd0; bus_if.wdata = 32'd0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_miso", {31'd0, spi_miso_out}, 32'd1);
    check("rst_miso_en", {31'd0, spi_miso_enable}, 32'd0);
    read_reg(8'h00, st);
    check("rst_status", st, 32'd0);
    read_reg(8'h04, st);
    check("rst_ctrl", st, 32'd0);

    // Unmapped address reads zero and ignores writes
    write_reg(8'h08, 4'hF, 32'hFFFF_FFFF);
    read_reg(8'h08, st);
    check("unmapped_rd", st, 32'd0);
    read_reg(8'h04, st);
    check("unmapped_wr_ignored", st, 32'd0);

    // Test 1: preloaded byte out, 0x3C in
    write_reg(8'h04, 4'h1, 32'h0000_00A5);
    read_reg(8'h04, st);
    check("t1_tx_full_set", st, 32'h8);
    cs_low();
    check("t1_miso_en", {31'd0, spi_miso_enable}, 32'd1);
    xfer(8'h3C, 4, 1'b0, m1);
    read_reg(8'h00, st);
    check("t1_mid_flags", {28'd0, st[31:28]}, 32'h8);
    xfer(8'hC0, 4, 1'b0, m2);
    check("t1_miso", {24'd0, m1[3:0], m2[3:0]}, 32'hA5);
    exp_q.push_back({1'b1, 8'h3C});
    cs_high();
    check("t1_miso_en_off", {31'd0, spi_miso_enable}, 32'd0);
    rd_status("t1", st);
    check("t1_end_underrun", {31'd0, st[29]}, 32'd1);

    // Test 2: three-byte frame, only the first byte preloaded
    write_reg(8'h04, 4'h2, 32'h0000_0200);
    write_reg(8'h04, 4'h1, 32'h0000_005A);
    cs_low();
    xfer(8'h9F, 8, 1'b0, m1);
    check("t2_miso0", {24'd0, m1}, 32'h5A);
    exp_q.push_back({1'b1, 8'h9F});
    xfer(8'h00, 8, 1'b0, m1);
    check("t2_miso1", {24'd0, m1}, 32'hFF);
    exp_q.push_back({1'b0, 8'h00});
    xfer(8'h00, 8, 1'b0, m1);
    check("t2_miso2", {24'd0, m1}, 32'hFF);
    exp_q.push_back({1'b0, 8'h00});
    cs_high();
    rd_status("t2a", st);
    check("t2_underrun", {31'd0, st[29]}, 32'd1);
    rd_status("t2b", st);
    rd_status("t2c", st);

    // Test 3: nine bytes into an 8-deep FIFO
    cs_low();
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom_range(0, 255));
      xfer(b, 8, 1'b0, m1);
      check("t3_miso_fill", {24'd0, m1}, 32'hFF);
      if (i < 8) exp_q.push_back({(i == 0), b});
    end
    cs_high();
    rd_status("t3a", st);
    check("t3_count8", {24'd0, st[23:16]}, 32'd8);
    check("t3_ovf_set", {31'd0, st[30]}, 32'd1);
    write_reg(8'h04, 4'h2, 32'h0000_0200);
    rd_status("t3b", st);
    check("t3_unr_clr", {30'd0, st[30:29]}, 32'h2);
    write_reg(8'h04, 4'h2, 32'h0000_0100);
    rd_status("t3c", st);
    check("t3_ovf_clr", {31'd0, st[30]}, 32'd0);
    for (int i = 0; i < 5; i++) rd_status("t3d", st);
    rd_status("t3e", st);

    // Test 4: frame aborted after 5 bits, then a clean frame
    cs_low();
    xfer(8'hE7, 5, 1'b0, m1);
    cs_high();
    rd_status("t4_abort", st);
    check("t4_count0", {24'd0, st[23:16]}, 32'd0);
    cs_low();
    xfer(8'hC3, 8, 1'b0, m1);
    exp_q.push_back({1'b1, 8'hC3});
    cs_high();
    rd_status("t4_aligned", st);

    // Test 5: pop on the exact cycle a push arrives while full
    cs_low();
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      xfer(b, 8, 1'b0, m1);
      exp_q.push_back({(i == 0), b});
    end
    b = 8'($urandom_range(0, 255));
    xfer(b, 8, 1'b1, m1);
    exp_q.push_back({1'b0, b});
    cs_high();
    rd_status("t5a", st);
    check("t5_count8", {24'd0, st[23:16]}, 32'd8);
    check("t5_no_ovf", {31'd0, st[30]}, 32'd0);
    for (int i = 0; i < 7; i++) rd_status("t5b", st);

    // Test 6: reset in the middle of a byte
    write_reg(8'h04, 4'h1, 32'h0000_0000);
    cs_low();
    write_reg(8'h04, 4'h1, 32'h0000_0077);
    xfer(8'h05, 3, 1'b0, m1);
    check("t6_pre_miso", {31'd0, spi_miso_out}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("t6_miso", {31'd0, spi_miso_out}, 32'd1);
    check("t6_miso_en", {31'd0, spi_miso_enable}, 32'd0);
    spi_cs = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    read_reg(8'h00, st);
    check("t6_status", st, 32'd0);
    read_reg(8'h04, st);
    check("t6_ctrl", st, 32'd0);
    write_reg(8'h04, 4'h1, 32'h0000_0096);
    cs_low();
    xfer(8'h81, 8, 1'b0, m1);
    check("t6_resume_miso", {24'd0, m1}, 32'h96);
    exp_q.push_back({1'b1, 8'h81});
    cs_high();
    rd_status("t6_resume", st);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
